// File: rtl/bp_pkg.sv
// Shared encodings and constants for the fetch-side branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [1:0]  CTR_RESET = WNT;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage : bp_pkg

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       taken_i,
    output logic [1:0] next_o
);

    always_comb begin
        // NOTE: assign a default first so no path through the block leaves next_o unassigned (which would infer a latch).
        next_o = cur_i;
        if (taken_i) begin
            if (cur_i != ST) next_o = cur_i + 2'd1;
        end else begin
            if (cur_i != SNT) next_o = cur_i - 2'd1;
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational Fetch prediction,
// Execute-stage mispredict detection, table training and perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        BranchE,
    input  logic        TakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] TargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE,
    output logic [15:0] BranchCount,
    output logic [15:0] MispredictCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]      tag_f, tag_e;
    logic                  hit_f, hit_e;
    logic [1:0]            ctr_trained;
    logic [1:0]            ctr_d;

    assign idx_f = PCF[INDEX_BITS+1:2];
    assign tag_f = PCF[31:INDEX_BITS+2];
    assign idx_e = PCE[INDEX_BITS+1:2];
    assign tag_e = PCE[31:INDEX_BITS+2];

    // Prediction is forced off while reset is held so Fetch falls through.
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF  = reset && hit_f && ctr_q[idx_f][1];
    assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + PC_STEP;

    assign MispredictE = BranchE &&
                         ((TakenE != PredTakenE) || (TakenE && (PredTargetE != TargetE)));
    assign RedirectPCE = TakenE ? TargetE : PCE + PC_STEP;

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    sat_counter2 u_sat_counter2 (
        .cur_i   (ctr_q[idx_e]),
        .taken_i (TakenE),
        .next_o  (ctr_trained)
    );

    // A miss allocates with a weak counter biased toward the observed outcome.
    assign ctr_d = hit_e ? ctr_trained : (TakenE ? WT : WNT);

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (BranchE && (branch_cnt_q != 16'hFFFF))      branch_cnt_d  = branch_cnt_q + 16'd1;
        if (MispredictE && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the table is a flat register array, so clearing every entry in reset is legal and required here; a RAM-backed table could not do this.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (BranchE) begin
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= TargetE;
                ctr_q[idx_e]    <= ctr_d;
            end
        end
    end

    assign BranchCount     = branch_cnt_q;
    assign MispredictCount = mispred_cnt_q;

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: prediction, training, aliasing,
// mispredict/redirect, reset priority and counter saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        BranchE;
    logic        TakenE;
    logic [31:0] PCE;
    logic [31:0] TargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic [15:0] BranchCount;
    logic [15:0] MispredictCount;

    int tests_run    = 0;
    int tests_failed = 0;

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .PCF             (PCF),
        .PredTakenF      (PredTakenF),
        .PredTargetF     (PredTargetF),
        .BranchE         (BranchE),
        .TakenE          (TakenE),
        .PCE             (PCE),
        .TargetE         (TargetE),
        .PredTakenE      (PredTakenE),
        .PredTargetE     (PredTargetE),
        .MispredictE     (MispredictE),
        .RedirectPCE     (RedirectPCE),
        .BranchCount     (BranchCount),
        .MispredictCount (MispredictCount)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset   = 1'b0;
        BranchE = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Present one branch in E, capture the combinational E outputs before the
    // training edge, then retire it.
    task automatic branch(input logic [31:0] pce, input logic taken, input logic [31:0] tgt,
                          input logic ptaken, input logic [31:0] ptgt,
                          output logic mp, output logic [31:0] rpc);
        BranchE = 1'b1; PCE = pce; TakenE = taken; TargetE = tgt;
        PredTakenE = ptaken; PredTargetE = ptgt;
        #1;
        mp  = MispredictE;
        rpc = RedirectPCE;
        @(posedge clk); #1;
        BranchE = 1'b0;
    endtask

    // Look up PCF and compare the prediction against expectations.
    task automatic fetch(input string name, input logic [31:0] pc,
                         input logic exp_taken, input logic [31:0] exp_tgt);
        PCF = pc;
        #1;
        tests_run++;
        if (PredTakenF !== exp_taken || PredTargetF !== exp_tgt) begin
            tests_failed++;
            $display("FAIL %s: pc=%h got taken=%b target=%h, expected taken=%b target=%h",
                     name, pc, PredTakenF, PredTargetF, exp_taken, exp_tgt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        fetch("reset_predict", 32'h100, 1'b0, 32'h104);
        fetch("reset_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        tests_run++;
        if (BranchCount !== 16'd0 || MispredictCount !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %h/%h, expected 0000/0000", BranchCount, MispredictCount);
        end
    endtask

    task automatic test_cold_miss();
        logic mp; logic [31:0] rpc;
        do_reset();
        branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, mp, rpc);
        tests_run++;
        if (mp !== 1'b1 || rpc !== 32'h80) begin
            tests_failed++;
            $display("FAIL cold_miss_redirect: got mp=%b rpc=%h, expected mp=1 rpc=00000080", mp, rpc);
        end
        fetch("cold_miss_trained", 32'h100, 1'b1, 32'h80);
        tests_run++;
        if (BranchCount !== 16'd1 || MispredictCount !== 16'd1) begin
            tests_failed++;
            $display("FAIL cold_miss_counters: got %h/%h, expected 0001/0001", BranchCount, MispredictCount);
        end
        // Correctly predicted not-taken branch elsewhere: no mispredict, fall-through redirect.
        branch(32'h204, 1'b0, 32'h300, 1'b0, 32'h208, mp, rpc);
        tests_run++;
        if (mp !== 1'b0 || rpc !== 32'h208) begin
            tests_failed++;
            $display("FAIL nt_correct: got mp=%b rpc=%h, expected mp=0 rpc=00000208", mp, rpc);
        end
        tests_run++;
        if (BranchCount !== 16'd2 || MispredictCount !== 16'd1) begin
            tests_failed++;
            $display("FAIL nt_counters: got %h/%h, expected 0002/0001", BranchCount, MispredictCount);
        end
    endtask

    task automatic test_saturation();
        logic mp; logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 4; i++) branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, mp, rpc);
        fetch("sat_st", 32'h100, 1'b1, 32'h80);
        branch(32'h100, 1'b0, 32'h80, 1'b1, 32'h80, mp, rpc);
        tests_run++;
        if (mp !== 1'b1 || rpc !== 32'h104) begin
            tests_failed++;
            $display("FAIL sat_nt_redirect: got mp=%b rpc=%h, expected mp=1 rpc=00000104", mp, rpc);
        end
        fetch("sat_wt", 32'h100, 1'b1, 32'h80);
        branch(32'h100, 1'b0, 32'h80, 1'b1, 32'h80, mp, rpc);
        fetch("sat_wnt", 32'h100, 1'b0, 32'h104);
        // Two more not-taken then one taken: SNT -> WNT, still not predicted taken.
        branch(32'h100, 1'b0, 32'h80, 1'b0, 32'h104, mp, rpc);
        branch(32'h100, 1'b0, 32'h80, 1'b0, 32'h104, mp, rpc);
        branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, mp, rpc);
        fetch("sat_snt_floor", 32'h100, 1'b0, 32'h104);
    endtask

    task automatic test_alias();
        logic mp; logic [31:0] rpc;
        do_reset();
        branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, mp, rpc);
        branch(32'h140, 1'b0, 32'h90, 1'b0, 32'h144, mp, rpc);
        fetch("alias_evicted", 32'h100, 1'b0, 32'h104);
        fetch("alias_new_wnt", 32'h140, 1'b0, 32'h144);
        // A hit at WNT goes SNT then back to WNT on taken; a miss would re-allocate at WT.
        branch(32'h140, 1'b0, 32'h90, 1'b0, 32'h144, mp, rpc);
        branch(32'h140, 1'b1, 32'h90, 1'b0, 32'h144, mp, rpc);
        fetch("alias_hit_trains", 32'h140, 1'b0, 32'h144);
    endtask

    task automatic test_target_mismatch();
        logic mp; logic [31:0] rpc;
        do_reset();
        branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, mp, rpc);
        branch(32'h100, 1'b1, 32'h90, 1'b1, 32'h80, mp, rpc);
        tests_run++;
        if (mp !== 1'b1 || rpc !== 32'h90) begin
            tests_failed++;
            $display("FAIL tgt_mismatch: got mp=%b rpc=%h, expected mp=1 rpc=00000090", mp, rpc);
        end
        fetch("tgt_updated", 32'h100, 1'b1, 32'h90);
        branch(32'h100, 1'b1, 32'h90, 1'b1, 32'h90, mp, rpc);
        tests_run++;
        if (mp !== 1'b0) begin
            tests_failed++;
            $display("FAIL tgt_match: got mp=%b, expected mp=0", mp);
        end
    endtask

    task automatic test_reset_with_branch();
        do_reset();
        reset = 1'b0;
        BranchE = 1'b1; PCE = 32'h200; TakenE = 1'b1; TargetE = 32'h40;
        PredTakenE = 1'b0; PredTargetE = 32'h204;
        #1;
        tests_run++;
        if (MispredictE !== 1'b1 || RedirectPCE !== 32'h40) begin
            tests_failed++;
            $display("FAIL reset_mp_follows: got mp=%b rpc=%h, expected mp=1 rpc=00000040", MispredictE, RedirectPCE);
        end
        @(posedge clk); #1;
        fetch("reset_held_predict", 32'h200, 1'b0, 32'h204);
        BranchE = 1'b0;
        reset = 1'b1;
        fetch("reset_no_alloc", 32'h200, 1'b0, 32'h204);
        tests_run++;
        if (BranchCount !== 16'd0 || MispredictCount !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_wins_counters: got %h/%h, expected 0000/0000", BranchCount, MispredictCount);
        end
    endtask

    task automatic test_counter_saturation();
        do_reset();
        BranchE = 1'b1; PCE = 32'h300; TakenE = 1'b1; TargetE = 32'h500;
        PredTakenE = 1'b0; PredTargetE = 32'h304;
        repeat (65534) @(posedge clk);
        #1;
        tests_run++;
        if (BranchCount !== 16'hFFFE || MispredictCount !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL cnt_fffe: got %h/%h, expected fffe/fffe", BranchCount, MispredictCount);
        end
        @(posedge clk); #1;
        tests_run++;
        if (BranchCount !== 16'hFFFF || MispredictCount !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL cnt_ffff: got %h/%h, expected ffff/ffff", BranchCount, MispredictCount);
        end
        @(posedge clk); #1;
        BranchE = 1'b0;
        tests_run++;
        if (BranchCount !== 16'hFFFF || MispredictCount !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL cnt_saturate: got %h/%h, expected ffff/ffff", BranchCount, MispredictCount);
        end
    endtask

    initial begin
        reset = 1'b0; PCF = 32'h0; BranchE = 1'b0; TakenE = 1'b0; PCE = 32'h0;
        TargetE = 32'h0; PredTakenE = 1'b0; PredTargetE = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_cold_miss();
        test_saturation();
        test_alias();
        test_target_mismatch();
        test_reset_with_branch();
        test_counter_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_branch_predictor
